// File: rtl/mem_stage.sv
// mem_stage: load/store decode, single-outstanding big-endian data-RAM access, write-back bundle to MEM/WB.
// Memory ops take IDLE + WAIT(>=1) + DONE with stallreq high until DONE; `MEM_ALIGN_CHECK_EN adds misalign_o.
`ifndef RegBus
`define RegBus 32
`endif
`ifndef RegAddrBus
`define RegAddrBus 5
`endif

module mem_stage (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`RegAddrBus-1:0] wd_i,
  input  logic                   wreg_i,
  input  logic [`RegBus-1:0]     wdata_i,
  input  logic [`RegBus-1:0]     hi_i,
  input  logic [`RegBus-1:0]     lo_i,
  input  logic                   whilo_i,
  input  logic [7:0]             aluop_i,
  input  logic [`RegBus-1:0]     mem_addr_i,
  input  logic [`RegBus-1:0]     reg2_i,
  input  logic                   flush,
  output logic [`RegAddrBus-1:0] wd_o,
  output logic                   wreg_o,
  output logic [`RegBus-1:0]     wdata_o,
  output logic [`RegBus-1:0]     hi_o,
  output logic [`RegBus-1:0]     lo_o,
  output logic                   whilo_o,
  output logic                   stallreq,
  output logic                   ram_req,
  output logic                   ram_we,
  output logic [`RegBus-1:0]     ram_addr,
  output logic [3:0]             ram_sel,
  output logic [`RegBus-1:0]     ram_wdata,
  input  logic                   ram_ack,
  input  logic [`RegBus-1:0]     ram_rdata
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                   misalign_o
`endif
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DROP} state_t;

  state_t              state_q, state_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [`RegBus-1:0]  ram_addr_q, ram_addr_d;
  logic [3:0]          ram_sel_q, ram_sel_d;
  logic [`RegBus-1:0]  ram_wdata_q, ram_wdata_d;
  logic [`RegBus-1:0]  buf_q, buf_d;

  logic                is_load, is_store, is_mem, is_byte, is_half, is_signed;
  logic                misalign, misalign_idle;
  logic [3:0]          sel;
  logic [`RegBus-1:0]  st_data, ld_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (aluop_i)
      OP_LB:   begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU:  begin is_load = 1'b1; is_byte = 1'b1; end
      OP_LH:   begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
      OP_LW:   is_load = 1'b1;
      OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:   is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // Big-endian lanes: the lowest byte address lives in bits [31:24].
  always_comb begin
    sel     = 4'b1111;
    st_data = reg2_i;
    if (is_byte) begin
      st_data = {4{reg2_i[7:0]}};
      case (mem_addr_i[1:0])
        2'd0:    sel = 4'b1000;
        2'd1:    sel = 4'b0100;
        2'd2:    sel = 4'b0010;
        default: sel = 4'b0001;
      endcase
    end else if (is_half) begin
      st_data = {2{reg2_i[15:0]}};
      sel     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
    end
  end

  always_comb begin
    case (mem_addr_i[1:0])
      2'd0:    ld_byte = buf_q[31:24];
      2'd1:    ld_byte = buf_q[23:16];
      2'd2:    ld_byte = buf_q[15:8];
      default: ld_byte = buf_q[7:0];
    endcase
    ld_half = mem_addr_i[1] ? buf_q[15:0] : buf_q[31:16];
    if (is_byte)      ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
    else if (is_half) ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
    else              ld_data = buf_q;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign   = (is_half & mem_addr_i[0]) |
                      (is_mem & ~is_byte & ~is_half & (mem_addr_i[1:0] != 2'b00));
  assign misalign_o = (state_q == S_IDLE) & misalign;
`else
  assign misalign   = 1'b0;
`endif
  assign misalign_idle = (state_q == S_IDLE) & misalign;

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    buf_d       = buf_q;
    stallreq    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem & ~flush & ~misalign) begin
          stallreq    = 1'b1;
          ram_req_d   = 1'b1;
          ram_we_d    = is_store;
          ram_addr_d  = {mem_addr_i[`RegBus-1:2], 2'b00};
          ram_sel_d   = sel;
          ram_wdata_d = st_data;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        stallreq = 1'b1;
        if (ram_ack) begin
          ram_req_d = 1'b0;
          buf_d     = ram_rdata;
          state_d   = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        // The abandoned access still owns the RAM; a new memory op waits for IDLE.
        stallreq = is_mem & ~flush;
        if (ram_ack) begin
          ram_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= 4'b0000;
      ram_wdata_q <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      buf_q       <= buf_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;

  assign wd_o    = wd_i;
  assign hi_o    = hi_i;
  assign lo_o    = lo_i;
  assign wdata_o = ((state_q == S_DONE) & is_load) ? ld_data : wdata_i;
  assign wreg_o  = wreg_i & ~stallreq & ~flush & ~misalign_idle;
  assign whilo_o = whilo_i & ~stallreq & ~flush;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model is compared every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i, wd_o;
  logic        wreg_i, wreg_o, whilo_i, whilo_o, flush, stallreq;
  logic [31:0] wdata_i, hi_i, lo_i, mem_addr_i, reg2_i, wdata_o, hi_o, lo_o;
  logic [7:0]  aluop_i;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush(flush),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_o(whilo_o), .stallreq(stallreq), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int f_size(input logic [7:0] op);
    if (op == 8'hE0 || op == 8'hE4 || op == 8'hE8) return 1;
    if (op == 8'hE1 || op == 8'hE5 || op == 8'hE9) return 2;
    if (op == 8'hE3 || op == 8'hEB) return 4;
    return 0;
  endfunction

  function automatic logic f_store(input logic [7:0] op);
    return (op == 8'hE8 || op == 8'hE9 || op == 8'hEB);
  endfunction

  function automatic logic f_mis(input logic [7:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    int sz;
    sz = f_size(op);
    return (sz > 1) && ((a % sz) != 0);
`else
    return (op == 8'hFF) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [3:0] f_sel(input logic [7:0] op, input logic [31:0] a);
    logic [3:0] s;
    if (f_size(op) == 1) begin s = 4'b1000; s = s >> a[1:0]; end
    else if (f_size(op) == 2) begin s = 4'b1100; s = s >> (2 * int'(a[1])); end
    else s = 4'b1111;
    return s;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [7:0] op, input logic [31:0] r);
    if (f_size(op) == 1) return 32'(r[7:0]) * 32'h0101_0101;
    if (f_size(op) == 2) return 32'(r[15:0]) * 32'h0001_0001;
    return r;
  endfunction

  function automatic logic [31:0] f_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] v;
    logic        sgn;
    sgn = (op == 8'hE0 || op == 8'hE1);
    if (f_size(op) == 1) begin
      v = (b >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f_size(op) == 2) begin
      v = (b >> (16 * (1 - int'(a[1])))) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else v = b;
    return v;
  endfunction

  // Transaction model: an access is outstanding (busy), possibly abandoned (drop), or its data is ready (done).
  logic        m_busy = 0, m_drop = 0, m_done = 0, m_we = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_buf = 0;
  logic [3:0]  m_sel = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_drop = 0; m_done = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_buf = 0; m_sel = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (ram_ack) begin
        m_busy = 0;
        m_done = !m_drop && !flush;
        m_buf  = ram_rdata;
        m_drop = 0;
      end else if (flush) m_drop = 1;
    end else if (f_size(aluop_i) != 0 && !flush && !f_mis(aluop_i, mem_addr_i)) begin
      m_busy  = 1;
      m_we    = f_store(aluop_i);
      m_addr  = mem_addr_i & 32'hFFFF_FFFC;
      m_sel   = f_sel(aluop_i, mem_addr_i);
      m_wdata = f_wdata(aluop_i, reg2_i);
    end
  end

  always @(negedge clk) begin : cmp
    logic mem, ld, mis, idle, stall;
    mem  = f_size(aluop_i) != 0;
    ld   = mem && !f_store(aluop_i);
    mis  = f_mis(aluop_i, mem_addr_i);
    idle = !m_busy && !m_done;
    if (m_done) stall = 0;
    else if (m_busy) stall = m_drop ? (mem && !flush) : 1'b1;
    else stall = mem && !flush && !mis;
    chk("stallreq", 32'(stallreq), 32'(stall));
    chk("wreg_o", 32'(wreg_o), 32'(wreg_i && !stall && !flush && !(idle && mis)));
    chk("whilo_o", 32'(whilo_o), 32'(whilo_i && !stall && !flush));
    chk("wdata_o", wdata_o, (m_done && ld) ? f_load(aluop_i, mem_addr_i, m_buf) : wdata_i);
    chk("wd_o", 32'(wd_o), 32'(wd_i));
    chk("hi_o", hi_o, hi_i);
    chk("lo_o", lo_o, lo_i);
    chk("ram_req", 32'(ram_req), 32'(m_busy));
    chk("ram_we", 32'(ram_we), 32'(m_we));
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_sel", 32'(ram_sel), 32'(m_sel));
    chk("ram_wdata", ram_wdata, m_wdata);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misalign_o", 32'(misalign_o), 32'(idle && mis));
`endif
  end

  int          stall_cnt, wreg_cnt;
  logic [31:0] got_wdata, got_addr, got_wd;
  logic [3:0]  got_sel;
  logic        got_we;

  task automatic nop();
    aluop_i = 8'h00; wd_i = 5'd0; wreg_i = 0; wdata_i = 0; whilo_i = 0;
    hi_i = 32'h0000_1111; lo_i = 32'h0000_2222; mem_addr_i = 0; reg2_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one memory op from IDLE; ack arrives in WAIT cycle number 'waits' (0 = first).
  task automatic access(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input int waits, input logic [31:0] rdata, input logic fl_done);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = 5'd7; wdata_i = 32'h55;
    wreg_i = !f_store(op); whilo_i = 1; ram_rdata = rdata;
    stall_cnt = 0; wreg_cnt = 0;
    @(negedge clk); stall_cnt += int'(stallreq); wreg_cnt += int'(wreg_o);
    tick();
    ram_ack = (waits == 0);
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (k == 0) begin got_sel = ram_sel; got_addr = ram_addr; got_wd = ram_wdata; got_we = ram_we; end
      stall_cnt += int'(stallreq); wreg_cnt += int'(wreg_o);
      tick();
      ram_ack = (k + 1 == waits);
    end
    flush = fl_done;
    @(negedge clk); stall_cnt += int'(stallreq); wreg_cnt += int'(wreg_o); got_wdata = wdata_o;
    tick();
    flush = 0; nop();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst = 1; flush = 0; ram_ack = 0; ram_rdata = 0; nop();
    #3;
    chk("reset ram_req", 32'(ram_req), 0);
    chk("reset ram_sel", 32'(ram_sel), 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset stallreq", 32'(stallreq), 0);
    #15 rst = 0;
    tick();

    access(8'hE3, 32'h100, 0, 1, 32'hDEAD_BEEF, 0);
    chk("lw stall cycles", 32'(stall_cnt), 3);
    chk("lw wdata", got_wdata, 32'hDEAD_BEEF);
    chk("lw wreg pulses", 32'(wreg_cnt), 1);
    chk("lw addr", got_addr, 32'h100);
    chk("lw sel", 32'(got_sel), 32'hF);

    access(8'hE0, 32'h103, 0, 0, 32'h0000_00F0, 0);
    chk("lb sel", 32'(got_sel), 32'b0001);
    chk("lb wdata", got_wdata, 32'hFFFF_FFF0);
    chk("lb stall cycles", 32'(stall_cnt), 2);
    access(8'hE4, 32'h103, 0, 0, 32'h0000_00F0, 0);
    chk("lbu wdata", got_wdata, 32'h0000_00F0);

    access(8'hE9, 32'h202, 32'h1234_ABCD, 2, 0, 0);
    chk("sh we", 32'(got_we), 1);
    chk("sh sel", 32'(got_sel), 32'b0011);
    chk("sh wdata", got_wd, 32'hABCD_ABCD);
    chk("sh addr", got_addr, 32'h200);
    chk("sh wreg pulses", 32'(wreg_cnt), 0);

    access(8'hE1, 32'h102, 0, 0, 32'h1234_8001, 0);
    chk("lh wdata", got_wdata, 32'hFFFF_8001);
    access(8'hE5, 32'h100, 0, 0, 32'h8001_1234, 0);
    chk("lhu wdata", got_wdata, 32'h0000_8001);
    access(8'hE8, 32'h101, 32'hCAFE_005A, 0, 0, 0);
    chk("sb sel", 32'(got_sel), 32'b0100);
    chk("sb wdata", got_wd, 32'h5A5A_5A5A);

    aluop_i = 8'h20; wdata_i = 5; wreg_i = 1; wd_i = 5'd9; whilo_i = 1; ram_ack = 1;
    @(negedge clk);
    chk("add wdata", wdata_o, 5);
    chk("add stallreq", 32'(stallreq), 0);
    chk("add wreg", 32'(wreg_o), 1);
    tick(); ram_ack = 0;
    @(negedge clk);
    chk("add ram_req", 32'(ram_req), 0);
    tick(); nop();

    access(8'hE3, 32'h104, 0, 0, 32'h1111_2222, 1);
    chk("flush in done wreg pulses", 32'(wreg_cnt), 0);

    aluop_i = 8'hE3; mem_addr_i = 32'h300; wreg_i = 1; wd_i = 5'd3;
    tick();
    flush = 1;
    @(negedge clk);
    chk("flush wait wreg", 32'(wreg_o), 0);
    tick();
    flush = 0; nop(); ram_ack = 1; ram_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("drop stallreq", 32'(stallreq), 0);
    chk("drop ram_req", 32'(ram_req), 1);
    chk("drop wreg", 32'(wreg_o), 0);
    tick(); ram_ack = 0;
    access(8'hE3, 32'h400, 0, 0, 32'h0BAD_F00D, 0);
    chk("after drop addr", got_addr, 32'h400);
    chk("after drop wdata", got_wdata, 32'h0BAD_F00D);

    aluop_i = 8'hE3; mem_addr_i = 32'h500; wreg_i = 1;
    tick();
    flush = 1;
    tick();
    flush = 0; mem_addr_i = 32'h600;
    @(negedge clk);
    chk("drop new op stallreq", 32'(stallreq), 1);
    chk("drop held addr", ram_addr, 32'h500);
    tick(); ram_ack = 1;
    tick(); ram_ack = 0;
    @(negedge clk);
    chk("reissue stallreq", 32'(stallreq), 1);
    tick();
    @(negedge clk);
    chk("reissue addr", ram_addr, 32'h600);
    ram_ack = 1; ram_rdata = 32'h0000_0600;
    tick(); ram_ack = 0;
    @(negedge clk);
    chk("reissue wdata", wdata_o, 32'h0000_0600);
    tick(); nop();

    aluop_i = 8'hE3; mem_addr_i = 32'h700; wreg_i = 1;
    tick();
    @(negedge clk);
    chk("pre-reset ram_req", 32'(ram_req), 1);
    #2 rst = 1;
    #1 chk("async reset ram_req", 32'(ram_req), 0);
    nop();
    #10 rst = 0;
    tick();

`ifdef MEM_ALIGN_CHECK_EN
    aluop_i = 8'hE3; mem_addr_i = 32'h101; wreg_i = 1;
    @(negedge clk);
    chk("misalign flag", 32'(misalign_o), 1);
    chk("misalign stallreq", 32'(stallreq), 0);
    chk("misalign wreg", 32'(wreg_o), 0);
    tick();
    @(negedge clk);
    chk("misalign ram_req", 32'(ram_req), 0);
    tick(); nop();
`else
    access(8'hE3, 32'h105, 0, 0, 32'hA5A5_0F0F, 0);
    chk("lw truncated addr", got_addr, 32'h104);
    chk("lw truncated wdata", got_wdata, 32'hA5A5_0F0F);
    access(8'hE1, 32'h103, 0, 0, 32'h1111_FEDC, 0);
    chk("lh truncated sel", 32'(got_sel), 32'b0011);
    chk("lh truncated wdata", got_wdata, 32'hFFFF_FEDC);
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
